rr_arbiter4: RTL and testbench

Round-robin arbiter that shares one 4-input datapath resource between four requesters. Drives the 2-bit `sel` of the downstream `mux4` and a one-hot `grant` vector, holds each grant for a multi-cycle transaction until the resource signals `done`, and enforces a bounded hold time so that no requester can starve the others. Sits between the requesting units (fetch, load/store, debug, DMA) and the shared `mux4` in front of the memory/bus port.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_arbiter4_if.sv | 24 ++
 rtl/rr_pick4.sv | 36 +++
 rtl/rr_arbiter4.sv | 117 +++++++++++
 tb/tb_rr_arbiter4.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: requester count,
// select width, FSM state encoding and a small index-to-one-hot helper.
package arb_pkg;

    localparam int NUM_REQ   = 4;
    localparam int SEL_WIDTH = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Convert a binary owner index into its one-hot grant pattern
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_WIDTH-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesting units, the shared resource and
// the arbiter. The arbiter uses the slave view; requesters and the resource
// (or a testbench) drive through the master view.
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0]   req;
    logic                 done;
    logic [NUM_REQ-1:0]   grant;
    logic [SEL_WIDTH-1:0] sel;
    logic                 busy;
    logic                 timeout;

    modport master (
        output req, done,
        input  grant, sel, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, busy, timeout
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: returns the first asserted request
// in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    // Requests rotated so that bit 0 is the highest-priority candidate
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_WIDTH-1:0] w_off;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign w_rot[gi] = req[ptr + SEL_WIDTH'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the winning offset from ptr
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_WIDTH'(k);
            end
        end
    end

    assign found = |w_rot;
    assign idx   = ptr + w_off;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with multi-cycle grants, release on done or
// request withdrawal, bounded hold time and zero-bubble hand-off between owners.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD  = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    rr_arbiter4_if.slave bus
);

    // Counter value seen in the last permitted cycle of a grant
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_WIDTH'(MAX_HOLD - 1);

    arb_state_t           r_state, r_state_next;
    logic [NUM_REQ-1:0]   r_grant, r_grant_next;
    logic [SEL_WIDTH-1:0] r_sel, r_sel_next;
    logic [SEL_WIDTH-1:0] r_ptr, r_ptr_next;
    logic [CNT_WIDTH-1:0] r_cnt, r_cnt_next;
    logic                 r_busy, r_busy_next;
    logic                 r_timeout, r_timeout_next;

    logic [SEL_WIDTH-1:0] w_pick_ptr;
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_idx;
    logic                 w_expire;
    logic                 w_owner_req;
    logic                 w_release;

    // On release the search starts just after the old owner so it ranks last
    assign w_pick_ptr  = (r_state == ST_BUSY) ? (r_sel + SEL_WIDTH'(1)) : r_ptr;
    assign w_expire    = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
    assign w_owner_req = bus.req[r_sel];
    assign w_release   = bus.done || !w_owner_req || w_expire;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // State register; reset clears everything without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= r_state_next;
            r_grant   <= r_grant_next;
            r_sel     <= r_sel_next;
            r_ptr     <= r_ptr_next;
            r_cnt     <= r_cnt_next;
            r_busy    <= r_busy_next;
            r_timeout <= r_timeout_next;
        end
    end

    // Next-state logic: grant from IDLE, hold/count in BUSY, hand off on release
    always_comb begin
        r_state_next   = r_state;
        r_grant_next   = r_grant;
        r_sel_next     = r_sel;
        r_ptr_next     = r_ptr;
        r_cnt_next     = r_cnt;
        r_timeout_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    r_state_next = ST_BUSY;
                    r_grant_next = idx_to_onehot(w_idx);
                    r_sel_next   = w_idx;
                    r_cnt_next   = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    r_ptr_next     = r_sel + SEL_WIDTH'(1);
                    // Only a pure counter expiry counts as a forced release
                    r_timeout_next = w_expire && !bus.done && w_owner_req;
                    if (w_found) begin
                        r_grant_next = idx_to_onehot(w_idx);
                        r_sel_next   = w_idx;
                        r_cnt_next   = '0;
                    end else begin
                        // sel keeps the last owner so the mux stays stable
                        r_state_next = ST_IDLE;
                        r_grant_next = '0;
                    end
                end else if (r_cnt != '1) begin
                    r_cnt_next = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                r_state_next = ST_IDLE;
                r_grant_next = '0;
            end
        endcase

        r_busy_next = |r_grant_next;
    end

    assign bus.grant   = r_grant;
    assign bus.sel     = r_sel;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand-written
// timeout / reset sequences, then randomized traffic against a queue-free
// behavioural model that tracks owner, pointer and cycles held as integers.
module tb_rr_arbiter4;
    import arb_pkg::*;

    localparam int MAX_HOLD = 16;

    logic clk;
    logic reset;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(
        .MAX_HOLD  (MAX_HOLD),
        .CNT_WIDTH (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: owner index (-1 = idle), pointer, cycles held, last owner
    int m_owner;
    int m_ptr;
    int m_held;
    int m_last_sel;
    bit m_to;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
    } vec_t;

    vec_t tbl [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic t);
        check({tag, ".grant"},   32'(bus.grant),   32'(g));
        check({tag, ".sel"},     32'(bus.sel),     32'(s));
        check({tag, ".busy"},    32'(bus.busy),    32'(b));
        check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_ptr      = 0;
        m_held     = 0;
        m_last_sel = 0;
        m_to       = 1'b0;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return -1;
    endfunction

    // One clock of arbitration, decided from the inputs sampled on that edge
    task automatic model_step(input logic [3:0] r, input logic d);
        int  w;
        bit  expired;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner    = w;
                m_held     = 1;
                m_last_sel = w;
            end
        end else begin
            expired = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (d || !r[m_owner] || expired) begin
                m_to  = expired && !d && r[m_owner];
                m_ptr = (m_owner + 1) % 4;
                w     = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner    = w;
                    m_held     = 1;
                    m_last_sel = w;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic do_reset();
        bus.req  = '0;
        bus.done = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] prev_g;

        tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[1]  = '{4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[2]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[11] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[12] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[14] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[15] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[16] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[17] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};

        // Reset state
        do_reset();
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            bus.req  = tbl[i].req;
            bus.done = tbl[i].done;
            tick();
            $display("vec %0d: req=%b done=%b -> grant=%b sel=%0d busy=%b timeout=%b",
                     i, tbl[i].req, tbl[i].done, bus.grant, bus.sel, bus.busy, bus.timeout);
            check_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].t);
        end

        // Timeout: owner 0 held for exactly MAX_HOLD cycles, then forced to 2
        do_reset();
        bus.req = 4'b0101;
        tick();
        check_all("to_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            check_all($sformatf("to_hold0_%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        $display("timeout: grant=%b sel=%0d timeout=%b", bus.grant, bus.sel, bus.timeout);
        check_all("to_expire", 4'b0100, 2'd2, 1'b1, 1'b1);

        // done coinciding with expiry: release happens, no timeout pulse
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            check_all($sformatf("to_hold2_%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        $display("done+expiry: grant=%b sel=%0d timeout=%b", bus.grant, bus.sel, bus.timeout);
        check_all("done_expire", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Sole requester regains the grant immediately after its own release
        bus.req  = 4'b0001;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_all("sole_regain", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Reset mid-transaction with owner 3: outputs clear before any edge
        bus.req = 4'b1000;
        tick();
        check_all("pre_rst_owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        #1 reset = 1'b1;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b1001;
        reset   = 1'b0;
        tick();
        $display("post-reset: req=1001 grant=%b sel=%0d", bus.grant, bus.sel);
        check_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Randomized traffic against the behavioural model
        do_reset();
        rq     = '0;
        prev_g = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                rq = '0;
                check_all("rnd_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
                continue;
            end
            if ($urandom_range(0, 11) == 0) rq = 4'($urandom_range(0, 15));
            bus.req  = rq;
            bus.done = ($urandom_range(0, 19) == 0);
            model_step(rq, bus.done);
            tick();
            check_all($sformatf("rnd%0d", c), model_grant(), 2'(m_last_sel),
                      (m_owner >= 0), m_to);
            if (bus.grant != prev_g)
                $display("rnd %0d: req=%b done=%b grant %b -> %b timeout=%b",
                         c, rq, bus.done, prev_g, bus.grant, bus.timeout);
            prev_g = bus.grant;
        end
        bus.done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
